idss_feeder: RTL and testbench

- Sequencer directly upstream of the input-data shift structure (four column-shift stages, one per input-channel lane).
- Accepts packed 3-row column beats from the external-memory read path over a valid/ready handshake.
- Drives row_1..row_3, LE_select and shift so each lane loads one column, then all lanes shift together.
- Raises window_valid to the downstream MAC array once full 3x3 windows are resident, and holds until acknowledged.

---
 rtl/idss_pkg.sv | 23 ++
 rtl/idss_feeder.sv | 136 +++++++++++++
 tb/tb_idss_feeder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/idss_pkg.sv
// Shared types and constants for the input-data shift structure feeder.
package idss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PRESENT,
    DONE
  } feeder_state_t;

  localparam logic [2:0] LE_NONE  = 3'b000;
  localparam logic [2:0] LE_LANE1 = 3'b001;
  localparam logic [2:0] LE_LANE2 = 3'b010;
  localparam logic [2:0] LE_LANE3 = 3'b011;
  localparam logic [2:0] LE_LANE4 = 3'b100;

  // in_data packing: word index of each row inside a column beat
  localparam int ROW1_OFS = 0;
  localparam int ROW2_OFS = 1;
  localparam int ROW3_OFS = 2;

endpackage

// File: rtl/idss_feeder.sv
// Column sequencer for the shift structure: beat shows on rows/LE one cycle after acceptance.
// Backpressure: in_ready only in LOAD; window_valid holds until window_ack.
module idss_feeder
  import idss_pkg::*;
#(
  parameter int IO_DATA_WIDTH     = 16,
  parameter int NB_LANES          = 4,
  parameter int WINDOW_COLS       = 3,
  parameter int FEATURE_MAP_WIDTH = 1024,
  parameter int COL_W             = $clog2(FEATURE_MAP_WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       start,
  input  logic [COL_W-1:0]           nb_cols,
  input  logic [3*IO_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [IO_DATA_WIDTH-1:0]   row_1,
  output logic [IO_DATA_WIDTH-1:0]   row_2,
  output logic [IO_DATA_WIDTH-1:0]   row_3,
  output logic [2:0]                 LE_select,
  output logic                       shift,
  output logic                       window_valid,
  input  logic                       window_ack,
  output logic                       busy,
  output logic                       done
);

  localparam int W = IO_DATA_WIDTH;

  feeder_state_t    state_q, state_d;
  logic [2:0]       lane_q, lane_d;
  logic [COL_W-1:0] col_q, col_d, nb_q, nb_d, col_inc, nb_clamped;
  logic [W-1:0]     row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;
  logic [2:0]       le_q, le_d;
  logic             shift_q, shift_d, wv_q, wv_d, busy_q, done_q;

  assign col_inc    = col_q + COL_W'(1);
  assign nb_clamped = (nb_cols > COL_W'(FEATURE_MAP_WIDTH)) ? COL_W'(FEATURE_MAP_WIDTH) : nb_cols;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    col_d   = col_q;
    nb_d    = nb_q;
    row1_d  = row1_q;
    row2_d  = row2_q;
    row3_d  = row3_q;
    le_d    = LE_NONE;
    shift_d = 1'b0;
    wv_d    = wv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nb_cols >= COL_W'(WINDOW_COLS)) begin
            nb_d    = nb_clamped;
            lane_d  = LE_LANE1;
            col_d   = '0;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          row1_d = in_data[ROW1_OFS*W +: W];
          row2_d = in_data[ROW2_OFS*W +: W];
          row3_d = in_data[ROW3_OFS*W +: W];
          le_d   = lane_q;
          if (lane_q == 3'(NB_LANES)) state_d = SHIFT;
          else                        lane_d  = lane_q + 3'd1;
        end
      end
      SHIFT: begin
        shift_d = 1'b1;
        col_d   = col_inc;
        lane_d  = LE_LANE1;
        state_d = (col_inc >= COL_W'(WINDOW_COLS)) ? PRESENT : LOAD;
      end
      PRESENT: begin
        // An ack only counts once window_valid is actually visible downstream.
        if (wv_q && window_ack) begin
          wv_d    = 1'b0;
          state_d = (col_q == nb_q) ? DONE : LOAD;
        end else begin
          wv_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= IDLE;
      lane_q  <= '0;
      col_q   <= '0;
      nb_q    <= '0;
      row1_q  <= '0;
      row2_q  <= '0;
      row3_q  <= '0;
      le_q    <= LE_NONE;
      shift_q <= 1'b0;
      wv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      col_q   <= col_d;
      nb_q    <= nb_d;
      row1_q  <= row1_d;
      row2_q  <= row2_d;
      row3_q  <= row3_d;
      le_q    <= le_d;
      shift_q <= shift_d;
      wv_q    <= wv_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign row_1        = row1_q;
  assign row_2        = row2_q;
  assign row_3        = row3_q;
  assign LE_select    = le_q;
  assign shift        = shift_q;
  assign window_valid = wv_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_idss_feeder.sv
// Self-checking bench for idss_feeder: random beats/gaps against an event-level strip model.
module tb_idss_feeder;

  localparam int W     = 16;
  localparam int COL_W = 11;
  localparam int LANES = 4;
  localparam int WCOLS = 3;
  localparam int FMW   = 1024;

  logic             clk = 1'b0;
  logic             arst_n_in = 1'b0;
  logic             start = 1'b0;
  logic [COL_W-1:0] nb_cols = '0;
  logic [3*W-1:0]   in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     row_1, row_2, row_3;
  logic [2:0]       LE_select;
  logic             shift, window_valid, busy, done;
  logic             window_ack = 1'b0;

  idss_feeder dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .nb_cols(nb_cols),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .row_1(row_1), .row_2(row_2), .row_3(row_3), .LE_select(LE_select),
    .shift(shift), .window_valid(window_valid), .window_ack(window_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of one strip: accepted beats in order, plus event counters.
  logic [3*W-1:0] beat_q[$];
  int le_cnt, sh_cnt, win_cnt, done_cnt, acc_cnt;
  int cyc = 0, wv_rise_cyc = 0, done_cyc = 0, wv_len = 0;
  logic [2:0] prev_le = '0;
  logic prev_wv = 1'b0;
  int drive_mode = 0;  // 0: in_valid set by the sequence, 1: held high, 2: random gaps
  int ack_mode   = 0;  // 0: never, 1: always high, 2: after window held 4 cycles

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    beat_q.delete();
    le_cnt = 0; sh_cnt = 0; win_cnt = 0; done_cnt = 0; acc_cnt = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (arst_n_in) begin
      if (LE_select != 3'd0) begin
        check("le_lane_order", 64'(LE_select), 64'((le_cnt % LANES) + 1));
        if (beat_q.size() == 0) check("row_without_beat", 64'(0), 64'(1));
        else check("rows_match_beat", 64'({row_3, row_2, row_1}), 64'(beat_q.pop_front()));
        le_cnt++;
      end
      if (shift) begin
        check("shift_after_last_lane", 64'(prev_le), 64'(LANES));
        check("le_shift_overlap", 64'(LE_select), 64'(0));
        sh_cnt++;
      end
      if (window_valid && !prev_wv) begin
        check("window_after_cols", 64'(sh_cnt), 64'(win_cnt + WCOLS));
        win_cnt++;
        wv_rise_cyc = cyc;
      end
      if (!window_valid && prev_wv) check("window_held_until_ack", 64'(window_ack), 64'(1));
      if (done) begin
        check("busy_during_done", 64'(busy), 64'(1));
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_le = LE_select;
    prev_wv = window_valid;
    wv_len  = window_valid ? wv_len + 1 : 0;
    case (ack_mode)
      1:       window_ack = 1'b1;
      2:       window_ack = window_valid && (wv_len >= 4);
      default: window_ack = 1'b0;
    endcase
    if (drive_mode == 1) in_valid = 1'b1;
    else if (drive_mode == 2) in_valid = ($urandom % 3) != 0;
    in_data = {16'($urandom), 32'($urandom)};
    if (arst_n_in && in_valid && in_ready) begin
      beat_q.push_back(in_data);
      acc_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int nb);
    start   = 1'b1;
    nb_cols = COL_W'(nb);
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_timeout"}, 64'(done_cnt > 0), 64'(1));
  endtask

  task automatic wait_le(input int target, input int budget);
    int n = 0;
    while (le_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("le_progress_timeout", 64'(le_cnt >= target), 64'(1));
  endtask

  task automatic check_strip(input string tag, input int nb);
    int eff;
    eff = (nb > FMW) ? FMW : nb;
    if (eff < WCOLS) eff = 0;
    check({tag, "_le_pulses"}, 64'(le_cnt), 64'(LANES * eff));
    check({tag, "_shifts"},    64'(sh_cnt), 64'(eff));
    check({tag, "_windows"},   64'(win_cnt), 64'((eff == 0) ? 0 : eff - WCOLS + 1));
    check({tag, "_beats"},     64'(acc_cnt), 64'(LANES * eff));
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_queue_empty"}, 64'(beat_q.size()), 64'(0));
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rows"},  64'({row_3, row_2, row_1}), 64'(0));
    check({tag, "_le"},    64'(LE_select), 64'(0));
    check({tag, "_shift"}, 64'(shift), 64'(0));
    check({tag, "_wv"},    64'(window_valid), 64'(0));
    check({tag, "_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_busy"},  64'(busy), 64'(0));
    check({tag, "_done"},  64'(done), 64'(0));
  endtask

  initial begin
    // Reset, then idle with in_valid high: nothing consumed.
    in_valid = 1'b1;
    repeat (3) tick();
    check_all_zero("in_reset");
    arst_n_in = 1'b1;
    clear_model();
    repeat (5) tick();
    check_all_zero("idle");
    check("idle_no_beats", 64'(acc_cnt), 64'(0));

    // Minimal strip, data always valid, ack always high.
    drive_mode = 1; ack_mode = 1;
    clear_model();
    pulse_start(3);
    wait_done("s3", 2000);
    check("s3_done_after_window", 64'(done_cyc - wv_rise_cyc), 64'(1));
    check_strip("s3", 3);

    // Random gaps, ack delayed.
    drive_mode = 2; ack_mode = 2;
    clear_model();
    pulse_start(5);
    wait_done("s5", 4000);
    check_strip("s5", 5);

    // Too-short strip: immediate done, no activity.
    drive_mode = 1; ack_mode = 1;
    clear_model();
    pulse_start(2);
    wait_done("s2", 50);
    check_strip("s2", 2);

    // Second start during LOAD must be ignored.
    clear_model();
    pulse_start(3);
    wait_le(2, 200);
    pulse_start(7);
    wait_done("restart", 2000);
    check_strip("restart", 3);

    // Oversized strip is clamped to the feature map width.
    clear_model();
    pulse_start(2047);
    wait_done("clamp", 20000);
    check_strip("clamp", 2047);

    // Reset mid-strip after 6 beats, then a clean strip.
    drive_mode = 2; ack_mode = 2;
    clear_model();
    pulse_start(4);
    wait_le(6, 500);
    @(posedge clk);
    #2 arst_n_in = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) tick();
    clear_model();
    arst_n_in = 1'b1;
    tick();
    check("post_reset_idle", 64'(busy), 64'(0));
    drive_mode = 1; ack_mode = 1;
    clear_model();
    pulse_start(3);
    wait_done("after_reset", 2000);
    check_strip("after_reset", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
